decoder_4_16_seq: RTL and testbench

Sequenced 4-to-16 one-hot decoder. It is the inverse of the 16-to-4 encoder.
- Takes a start index and an end index, then emits one-hot select words one per accepted transfer under a valid/ready handshake.
- Used for register/set walks, e.g. cache set invalidation or bank-enable sequencing.
- Combinational decode is done by a leaf sub-module. This block adds the control FSM, index counter and output register.

---
 rtl/decoder_4_16_seq_pkg.sv | 20 ++
 rtl/decoder_4_16.sv | 26 ++
 rtl/decoder_4_16_seq.sv | 129 ++++++++++++
 tb/tb_decoder_4_16_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_4_16_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_4_16_seq_pkg
//  Description : Shared constants for the sequenced 4-to-16 decoder: index
//                width, one-hot word width and control FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder_4_16_seq_pkg;

    // Index width and the matching one-hot word width.
    localparam int IDX_W  = 4;
    localparam int WORD_W = 16;

    // Control FSM state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : decoder_4_16_seq_pkg
`default_nettype wire

// File: rtl/decoder_4_16.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_4_16
//  Description : Purely combinational W-to-2**W one-hot decoder. Index a sets
//                bit a of y, where bit 0 is the leftmost (most significant)
//                bit, so a=0 gives 16'h8000 and a=15 gives 16'h0001.
//  Ports       : a [0:W-1]       - index in
//                y [0:2**W-1]    - one-hot word out
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_4_16
    import decoder_4_16_seq_pkg::*;
#(
    parameter int W = IDX_W
) (
    input  logic [0:W-1]      a,
    output logic [0:2**W-1]   y
);

    always_comb begin
        y    = '0;
        y[a] = 1'b1;
    end

endmodule : decoder_4_16
`default_nettype wire

// File: rtl/decoder_4_16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_4_16_seq
//  Description : Sequenced one-hot decoder. On a start request it latches a
//                first/last index and mode, then delivers one registered
//                one-hot word per valid/ready transfer (a single word in
//                single mode, first..last with wrap in sweep mode), followed
//                by a one-cycle done pulse.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                start  - request, sampled only in IDLE
//                mode   - 0 single word, 1 sweep first..last
//                first  - start index
//                last   - end index (sweep only)
//                ready  - consumer accepts the current word
//                valid  - y/idx hold a word
//                y      - registered one-hot word (zero when valid=0)
//                idx    - index of the current word
//                busy   - FSM not in IDLE
//                done   - one-cycle pulse after the final transfer
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_4_16_seq
    import decoder_4_16_seq_pkg::*;
#(
    parameter int W = IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [0:W-1]      first,
    input  logic [0:W-1]      last,
    input  logic              ready,
    output logic              valid,
    output logic [0:2**W-1]   y,
    output logic [0:W-1]      idx,
    output logic              busy,
    output logic              done
);

    logic [1:0]          r_state;
    logic [0:W-1]        r_idx;
    logic [0:W-1]        r_last;
    logic                r_mode;
    logic                r_valid;
    logic [0:2**W-1]     r_y;
    logic                r_done;

    logic                w_transfer;
    logic                w_final;
    logic [0:W-1]        w_idx_inc;
    logic [0:W-1]        w_dec_idx;
    logic [0:2**W-1]     w_dec_y;

    // r_valid is only ever set in RUN, so it alone qualifies a transfer.
    assign w_transfer = r_valid & ready;
    assign w_final    = ~r_mode | (r_idx == r_last);
    // Natural W-bit overflow gives the 15 -> 0 wrap.
    assign w_idx_inc  = r_idx + 1'b1;

    // One shared decoder feeds the output register: in IDLE it decodes the
    // incoming first index, in RUN it decodes the next index of the sweep.
    assign w_dec_idx  = (r_state == ST_IDLE) ? first : w_idx_inc;

    decoder_4_16 #(
        .W (W)
    ) u_decoder (
        .a (w_dec_idx),
        .y (w_dec_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_last  <= '0;
            r_mode  <= 1'b0;
            r_valid <= 1'b0;
            r_y     <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_idx   <= first;
                        r_last  <= last;
                        r_mode  <= mode;
                        r_valid <= 1'b1;
                        r_y     <= w_dec_y;
                    end
                end
                ST_RUN: begin
                    // Without a transfer everything holds (stall).
                    if (w_transfer) begin
                        if (w_final) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_y     <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= w_idx_inc;
                            r_y     <= w_dec_y;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_y     <= '0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign valid = r_valid;
    assign y     = r_y;
    assign idx   = r_idx;
    assign busy  = (r_state != ST_IDLE);
    assign done  = r_done;

endmodule : decoder_4_16_seq
`default_nettype wire

// File: tb/tb_decoder_4_16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_4_16_seq
//  Description : Directed self-checking bench for decoder_4_16_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_4_16_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [0:3]  first;
    logic [0:3]  last;
    logic        ready;
    logic        valid;
    logic [0:15] y;
    logic [0:3]  idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    decoder_4_16_seq #(
        .W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .first (first),
        .last  (last),
        .ready (ready),
        .valid (valid),
        .y     (y),
        .idx   (idx),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the currently presented word.
    task automatic chk_word(input string tag, input logic [15:0] ey, input logic [3:0] ei);
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".y"},     32'(y),     32'(ey));
        chk({tag, ".idx"},   32'(idx),   32'(ei));
        chk({tag, ".busy"},  32'(busy),  32'd1);
    endtask

    // Check the DONE cycle and the return to IDLE one cycle later.
    task automatic chk_done(input string tag);
        chk({tag, ".done"},       32'(done),  32'd1);
        chk({tag, ".done_valid"}, 32'(valid), 32'd0);
        chk({tag, ".done_y"},     32'(y),     32'd0);
        chk({tag, ".done_busy"},  32'(busy),  32'd1);
        step();
        chk({tag, ".idle_done"},  32'(done),  32'd0);
        chk({tag, ".idle_busy"},  32'(busy),  32'd0);
        chk({tag, ".idle_valid"}, 32'(valid), 32'd0);
    endtask

    task automatic launch(input logic m, input logic [3:0] f, input logic [3:0] l);
        start = 1'b1;
        mode  = m;
        first = f;
        last  = l;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        first = 4'd0;
        last  = 4'd0;
        ready = 1'b0;

        // ---------------- reset state
        step();
        step();
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.y",     32'(y),     32'd0);
        chk("rst.idx",   32'(idx),   32'd0);
        chk("rst.busy",  32'(busy),  32'd0);
        chk("rst.done",  32'(done),  32'd0);
        rst_n = 1'b1;
        step();

        // ---------------- single, first=0
        ready = 1'b1;
        launch(1'b0, 4'd0, 4'd9);
        chk_word("s0", 16'h8000, 4'd0);
        step();
        chk_done("s0");

        // ---------------- single, first=15, 4 stall cycles
        ready = 1'b0;
        launch(1'b0, 4'd15, 4'd3);
        chk_word("s15", 16'h0001, 4'd15);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_word("s15.stall", 16'h0001, 4'd15);
        end
        ready = 1'b1;
        step();
        chk_done("s15");

        // ---------------- sweep 3..6; inputs changed after start have no effect
        launch(1'b1, 4'd3, 4'd6);
        mode  = 1'b0;
        first = 4'd12;
        last  = 4'd3;
        chk_word("sw36.w0", 16'h1000, 4'd3);
        step();
        chk_word("sw36.w1", 16'h0800, 4'd4);
        step();
        chk_word("sw36.w2", 16'h0400, 4'd5);
        step();
        chk_word("sw36.w3", 16'h0200, 4'd6);
        step();
        chk_done("sw36");

        // ---------------- wrap sweep 14..1
        launch(1'b1, 4'd14, 4'd1);
        chk_word("wr.w0", 16'h0002, 4'd14);
        step();
        chk_word("wr.w1", 16'h0001, 4'd15);
        step();
        chk_word("wr.w2", 16'h8000, 4'd0);
        step();
        chk_word("wr.w3", 16'h4000, 4'd1);
        step();
        chk_done("wr");

        // ---------------- full sweep 5..4 : 16 words
        launch(1'b1, 4'd5, 4'd4);
        for (int k = 0; k < 16; k++) begin
            logic [3:0]  ei;
            logic [15:0] ey;
            ei = 4'(5 + k);
            ey = 16'h8000 >> ei;
            chk_word("full", ey, ei);
            step();
        end
        chk_done("full");

        // ---------------- sweep 0..2, stall at idx 1, ignored start
        launch(1'b1, 4'd0, 4'd2);
        chk_word("st.w0", 16'h8000, 4'd0);
        step();
        chk_word("st.w1", 16'h4000, 4'd1);
        ready = 1'b0;
        start = 1'b1;
        first = 4'd9;
        step();
        start = 1'b0;
        chk_word("st.hold", 16'h4000, 4'd1);
        step();
        chk_word("st.hold", 16'h4000, 4'd1);
        step();
        chk_word("st.hold", 16'h4000, 4'd1);
        ready = 1'b1;
        step();
        chk_word("st.w2", 16'h2000, 4'd2);
        step();
        chk_done("st");

        // ---------------- asynchronous reset mid-sweep 0..7 at idx 2
        launch(1'b1, 4'd0, 4'd7);
        step();
        step();
        chk_word("ar.w2", 16'h2000, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.valid", 32'(valid), 32'd0);
        chk("ar.y",     32'(y),     32'd0);
        chk("ar.idx",   32'(idx),   32'd0);
        chk("ar.busy",  32'(busy),  32'd0);
        chk("ar.done",  32'(done),  32'd0);
        step();
        chk("ar.nodone", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        chk("ar.nodone2", 32'(done), 32'd0);
        chk("ar.idle",    32'(busy), 32'd0);
        launch(1'b0, 4'd7, 4'd0);
        chk_word("ar.fresh", 16'h0100, 4'd7);
        step();
        chk_done("ar.fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_decoder_4_16_seq
`default_nettype wire
